// File: rtl/demux_1_2_32_bit_pipe.sv
// Registered 1-to-2 steering stage: one input word per cycle is parked in the
// holding slot of the selected destination; each slot drains through its own valid/ready port.
module demux_1_2_32_bit_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready
);

  // Handshake: a word moves across a port in any cycle where valid && ready
  // are both high at the rising edge; valid never depends on ready.

  logic                  full0_q, full0_d;
  logic                  full1_q, full1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic                  drain0, drain1;
  logic                  load0, load1;
  logic                  accept;

  // Only the selected slot gates in_ready, so a stalled sink never blocks the other.
  always_comb begin
    drain0   = full0_q && out0_ready;
    drain1   = full1_q && out1_ready;
    in_ready = !reset && !flush &&
               (in_select ? (!full1_q || out1_ready) : (!full0_q || out0_ready));
    accept   = in_valid && in_ready;
    load0    = accept && !in_select;
    load1    = accept && in_select;
  end

  always_comb begin
    full0_d = full0_q;
    data0_d = data0_q;
    if (flush) begin
      full0_d = 1'b0;
    end else if (load0) begin
      full0_d = 1'b1;
      data0_d = in_data;
    end else if (drain0) begin
      full0_d = 1'b0;
    end
  end

  always_comb begin
    full1_d = full1_q;
    data1_d = data1_q;
    if (flush) begin
      full1_d = 1'b0;
    end else if (load1) begin
      full1_d = 1'b1;
      data1_d = in_data;
    end else if (drain1) begin
      full1_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // Valid is masked while reset is held so sinks see nothing before the first edge.
  always_comb begin
    out0_valid = full0_q && !reset;
    out1_valid = full1_q && !reset;
    out0_data  = data0_q;
    out1_data  = data1_q;
  end

endmodule

// File: tb/tb_demux_1_2_32_bit_pipe.sv
// Directed bench for demux_1_2_32_bit_pipe: a table of per-cycle input and
// expected-output records plus hand-written reset and long-stall sequences.
module tb_demux_1_2_32_bit_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_select = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic        sel;
    logic [31:0] din;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vq[$];

  demux_1_2_32_bit_pipe #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (in_valid) begin
      assert (!$isunknown(in_select))
        else $error("protocol: in_select unknown while in_valid");
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic iv, input logic sel,
                     input logic [31:0] din, input logic r0, input logic r1,
                     input logic e_rdy, input logic e_v0, input logic [31:0] e_d0,
                     input logic e_v1, input logic [31:0] e_d1);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.sel = sel; v.din = din;
    v.r0 = r0; v.r1 = r1; v.e_rdy = e_rdy;
    v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_v1 = e_v1; v.e_d1 = e_d1;
    vq.push_back(v);
  endtask

  // Driver: inputs change just after the rising edge, outputs sampled on the falling edge.
  task automatic drive(input logic rst, input logic fl, input logic iv, input logic sel,
                       input logic [31:0] din, input logic r0, input logic r1);
    @(posedge clock);
    #1;
    reset = rst; flush = fl; in_valid = iv; in_select = sel;
    in_data = din; out0_ready = r0; out1_ready = r1;
    @(negedge clock);
  endtask

  initial begin
    bit seen_drop;

    // Table: rst fl iv sel din r0 r1 | rdy v0 d0 v1 d1
    // Two more idle cycles with fresh state after the hand reset sequence.
    add(0,0,0,0,32'h0,0,0, 1,0,32'h0,0,32'h0);
    // Single word to out1, one cycle later, then drained.
    add(0,0,1,1,32'hDEADBEEF,0,1, 1,0,32'h0,0,32'h0);
    add(0,0,0,0,32'h0,0,1,        1,0,32'h0,1,32'hDEADBEEF);
    add(0,0,0,0,32'h0,0,0,        1,0,32'h0,0,32'h0);
    // Streaming 0..7 into out0 with no bubbles.
    for (int i = 0; i < 8; i++)
      add(0,0,1,0,32'(i),1,0, 1,(i > 0),32'(i-1),0,32'h0);
    add(0,0,0,0,32'h0,1,0, 1,1,32'h7,0,32'h0);
    add(0,0,0,0,32'h0,0,0, 1,0,32'h0,0,32'h0);
    // Slot 0 stalled on A0 while out1 streams B0, B1.
    add(0,0,1,0,32'hA0,0,1, 1,0,32'h0,0,32'h0);
    add(0,0,1,1,32'hB0,0,1, 1,1,32'hA0,0,32'h0);
    add(0,0,1,1,32'hB1,0,1, 1,1,32'hA0,1,32'hB0);
    add(0,0,1,0,32'hA1,0,1, 0,1,32'hA0,1,32'hB1);
    add(0,0,0,0,32'h0,1,0,  1,1,32'hA0,0,32'h0);
    add(0,0,0,0,32'h0,0,0,  1,0,32'h0,0,32'h0);
    // Load and drain on the same edge.
    add(0,0,1,0,32'h11,0,0, 1,0,32'h0,0,32'h0);
    add(0,0,1,0,32'h22,1,0, 1,1,32'h11,0,32'h0);
    add(0,0,0,0,32'h0,1,0,  1,1,32'h22,0,32'h0);
    add(0,0,0,0,32'h0,0,0,  1,0,32'h0,0,32'h0);
    // Flush with both slots full and a word offered.
    add(0,0,1,0,32'h33,0,0, 1,0,32'h0,0,32'h0);
    add(0,0,1,1,32'h44,0,0, 1,1,32'h33,0,32'h0);
    add(0,1,1,0,32'h55,0,0, 0,1,32'h33,1,32'h44);
    add(0,0,0,0,32'h0,0,0,  1,0,32'h0,0,32'h0);
    add(0,0,0,0,32'h0,1,1,  1,0,32'h0,0,32'h0);
    // Reset while a slot is full masks valid and empties it.
    add(0,0,1,1,32'h66,0,0, 1,0,32'h0,0,32'h0);
    add(0,0,1,1,32'h77,0,0, 0,0,32'h0,1,32'h66);
    add(1,0,1,1,32'h77,0,0, 0,0,32'h0,0,32'h0);
    add(0,0,0,1,32'h0,0,0,  1,0,32'h0,0,32'h0);

    // Hand sequence: reset held two cycles with in_valid high.
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1,0,1,0,32'hFFFF_FFFF,1,1);
      check("reset_in_ready", 32'(in_ready), 32'h0);
      check("reset_out0_valid", 32'(out0_valid), 32'h0);
      check("reset_out1_valid", 32'(out1_valid), 32'h0);
    end
    drive(0,0,0,0,32'h0,0,0);
    check("post_reset_in_ready", 32'(in_ready), 32'h1);
    check("post_reset_out0_valid", 32'(out0_valid), 32'h0);
    check("post_reset_out1_valid", 32'(out1_valid), 32'h0);
    check("post_reset_out0_data", out0_data, 32'h0);
    check("post_reset_out1_data", out1_data, 32'h0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].fl, vq[k].iv, vq[k].sel, vq[k].din, vq[k].r0, vq[k].r1);
      check($sformatf("row%0d_in_ready", k), 32'(in_ready), 32'(vq[k].e_rdy));
      check($sformatf("row%0d_out0_valid", k), 32'(out0_valid), 32'(vq[k].e_v0));
      check($sformatf("row%0d_out1_valid", k), 32'(out1_valid), 32'(vq[k].e_v1));
      if (vq[k].e_v0) check($sformatf("row%0d_out0_data", k), out0_data, vq[k].e_d0);
      if (vq[k].e_v1) check($sformatf("row%0d_out1_data", k), out1_data, vq[k].e_d1);
    end

    // Hand sequence: long stall on out1, data stable, sel=1 blocked, sel=0 still open.
    drive(0,0,1,1,32'hC0DE0001,0,0);
    for (int c = 0; c < 3; c++) begin
      drive(0,0,1,1,32'hBAD0BAD0,0,0);
      check("stall_out1_valid", 32'(out1_valid), 32'h1);
      check("stall_out1_data", out1_data, 32'hC0DE0001);
      check("stall_in_ready_sel1", 32'(in_ready), 32'h0);
    end
    drive(0,0,0,0,32'h0,0,0);
    check("stall_in_ready_sel0", 32'(in_ready), 32'h1);
    check("stall_hold_out1_data", out1_data, 32'hC0DE0001);
    // Release sink 1 and wait a bounded number of cycles for the slot to empty.
    seen_drop = 1'b0;
    for (int c = 0; c < 4 && !seen_drop; c++) begin
      drive(0,0,0,0,32'h0,0,1);
      if (!out1_valid) seen_drop = 1'b1;
    end
    check("stall_release_drop", 32'(seen_drop), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
